nibble_sub_sequencer: RTL
=========================

Name: nibble_sub_sequencer

Overview:
- Performs a W-bit subtraction (W = 4*NIBBLES) by time-multiplexing one external 4-bit parallel subtractor, one nibble per cycle, LSB nibble first.
- Chains the borrow between nibbles.
- Sits between a requester (valid/ready request channel) and the shared 4-bit subtractor datapath.
- Returns the full-width difference and borrow-out on a valid/ready response channel.

Parameters:
- NIBBLES, 4, number of 4-bit slices; W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_a  in  W  minuend
- req_b  in  W  subtrahend
- req_bin  in  1  borrow-in to the LSB nibble
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer ready
- rsp_diff  out  W  difference
- rsp_bout  out  1  borrow-out of the MSB nibble
- busy  out  1  high in RUN or DONE
- sub_a  out  4  nibble minuend to the subtractor
- sub_b  out  4  nibble subtrahend to the subtractor
- sub_bin  out  1  borrow-in to the subtractor
- sub_diff  in  4  subtractor difference (combinational)
- sub_bout  in  1  subtractor borrow-out (combinational)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values:
  - State IDLE.
  - rsp_valid=0, rsp_diff=0, rsp_bout=0, busy=0.
  - sub_a=0, sub_b=0, sub_bin=0.
  - Internal index=0, borrow=0.
  - req_ready=1 from the first cycle after rst deasserts. req_ready=0 while rst=1.
- States: IDLE, RUN, DONE. req_ready = (state==IDLE) & !rst. busy = (state!=IDLE).
- IDLE:
  - On req_valid & req_ready: latch req_a, req_b, req_bin into operand registers. Set index=0, borrow=req_bin, clear result register. Go to RUN.
- RUN:
  - Drive sub_a = a[4*index+3 : 4*index], sub_b = b[same slice], sub_bin = borrow.
  - Each cycle, capture sub_diff into result slice [index] and capture borrow <= sub_bout.
  - If index == NIBBLES-1, go to DONE; otherwise index <= index+1.
  - Exactly NIBBLES cycles are spent in RUN.
- DONE:
  - rsp_valid=1; rsp_diff = result; rsp_bout = final borrow.
  - rsp_diff and rsp_bout stay stable while rsp_valid & !rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Outside RUN, sub_a, sub_b and sub_bin are driven 0.
- Latency: rsp_valid rises NIBBLES+1 cycles after the accept edge.
- Throughput: one result per NIBBLES+2 cycles minimum. There is no overlap: req_ready is low in DONE, even during the rsp handshake cycle.
- Arithmetic: rsp_diff = (req_a - req_b - req_bin) mod 2^W. rsp_bout = 1 iff req_a < req_b + req_bin (unsigned). The controller trusts sub_bout.
- Boundary conditions:
  - req_valid held high while busy is ignored; it is not queued.
  - Input changes on req_* after accept have no effect.
  - NIBBLES=1: RUN lasts 1 cycle.
  - rst asserted in any state: next cycle is IDLE with all reset values. An in-flight operation is discarded and no response is produced.
  - rst and req_valid in the same cycle: reset wins and the request is not accepted.

Optional Feature:
- Macro: NIBBLE_SUB_SAT_EN.
- Defined: on entry to DONE, if the final borrow is 1, rsp_diff is forced to 0 (unsigned saturation). rsp_bout still reports 1.
- Undefined: rsp_diff is the modular result.
- Latency and handshake are identical with or without the macro.

Test Plan:
- The bench models the 4-bit subtractor combinationally: sub_diff = sub_a - sub_b - sub_bin, sub_bout = borrow.
- NIBBLES=4, a=0x1234, b=0x0011, bin=0, rsp_ready=1 -> rsp_diff=0x1223, rsp_bout=0; rsp_valid high exactly 5 cycles after accept; sub_a sequence 4,3,2,1.
- NIBBLES=4, a=0x0000, b=0x0001, bin=0 -> rsp_diff=0xFFFF, rsp_bout=1. With NIBBLE_SUB_SAT_EN -> rsp_diff=0x0000, rsp_bout=1.
- NIBBLES=4, a=0x1000, b=0x0001, bin=1 -> borrow ripples through nibbles 0-2; rsp_diff=0x0FFE, rsp_bout=0.
- NIBBLES=1, a=0xA, b=0x3, bin=1 -> rsp_diff=0x6, rsp_bout=0, latency 2. Hold rsp_ready=0 for 3 cycles -> rsp_diff stable and req_ready=0 throughout; IDLE one cycle after the handshake.
- NIBBLES=4, assert rst for 1 cycle while in RUN at index=2 -> next cycle: rsp_valid=0, busy=0, sub_*=0, req_ready=1; a new request 0x0005-0x0003 then yields 0x0002, bout=0.

Source files
------------

// File: rtl/nibble_sub_sequencer.sv
// Serial W-bit subtractor: drives one shared 4-bit subtractor a nibble per cycle, LSB first.
// Optional: define NIBBLE_SUB_SAT_EN to clamp the difference to 0 when the final borrow is set.
module nibble_sub_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4*NIBBLES-1:0]   req_a,
  input  logic [4*NIBBLES-1:0]   req_b,
  input  logic                   req_bin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_diff,
  output logic                   rsp_bout,
  output logic                   busy,
  output logic [3:0]             sub_a,
  output logic [3:0]             sub_b,
  output logic                   sub_bin,
  input  logic [3:0]             sub_diff,
  input  logic                   sub_bout
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            borrow_q, borrow_d;
  logic            accept;

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (idx_q == LastIdx) state_d = StDone;
      StDone:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand, result and borrow registers
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    if (accept) begin
      a_d      = req_a;
      b_d      = req_b;
      res_d    = '0;
      idx_d    = '0;
      borrow_d = req_bin;
    end else if (state_q == StRun) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IdxW'(i)) res_d[4*i +: 4] = sub_diff;
      end
      borrow_d = sub_bout;
      if (idx_q != LastIdx) begin
        idx_d = idx_q + 1'b1;
      end
`ifdef NIBBLE_SUB_SAT_EN
      else if (sub_bout) begin
        res_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    req_ready = (state_q == StIdle) & ~rst;
    busy      = (state_q != StIdle);
    rsp_valid = (state_q == StDone);
    rsp_diff  = rsp_valid ? res_q : '0;
    rsp_bout  = rsp_valid & borrow_q;
    sub_a     = 4'h0;
    sub_b     = 4'h0;
    sub_bin   = 1'b0;
    if (state_q == StRun) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IdxW'(i)) begin
          sub_a = a_q[4*i +: 4];
          sub_b = b_q[4*i +: 4];
        end
      end
      sub_bin = borrow_q;
    end
  end

endmodule
